// File: rtl/fsm_bin_palin_det_param.sv
// fsm_bin_palin_det_param: serial LEN-bit palindrome detector, framed or sliding window
module fsm_bin_palin_det_param #(
  parameter int LEN     = 5,
  parameter int OVERLAP = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             in_valid,
  input  logic             clr,
  output logic             det,
  output logic [LEN-1:0]   det_word,
  output logic [CNT_W-1:0] det_cnt,
  output logic             busy
);
  localparam int BW = $clog2(LEN);
  localparam logic [BW-1:0] LAST = BW'(LEN - 1);
  typedef enum logic {S_FILL, S_RUN} state_t;
  state_t         r_state;
  logic [BW-1:0]  r_bit_cnt;
  logic [LEN-2:0] r_shreg;
  logic [LEN-1:0] w_win;
  logic           w_pal;
  logic           w_hit;
  assign w_win = {r_shreg, ser_in};
  assign w_hit = in_valid && w_pal && (r_state == S_RUN || r_bit_cnt == LAST);
  assign busy  = r_state == S_FILL && r_bit_cnt != '0;
  // middle bit of an odd-length window never participates
  always_comb begin
    w_pal = 1'b1;
    for (int i = 0; i < LEN / 2; i++) w_pal = w_pal && (w_win[i] == w_win[LEN-1-i]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FILL;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      det       <= 1'b0;
      det_word  <= '0;
      det_cnt   <= '0;
    end else if (clr) begin
      r_state   <= S_FILL;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      det       <= 1'b0;
      det_cnt   <= '0;
    end else begin
      det <= w_hit;
      if (in_valid) begin
        r_shreg <= w_win[LEN-2:0];
        if (r_state == S_FILL && r_bit_cnt == LAST) begin
          r_bit_cnt <= (OVERLAP != 0) ? LAST : '0;
          r_state   <= (OVERLAP != 0) ? S_RUN : S_FILL;
        end else if (r_state == S_FILL) begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        if (w_hit) begin
          det_word <= w_win;
          det_cnt  <= (&det_cnt) ? det_cnt : det_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fsm_bin_palin_det_param.sv
// tb_fsm_bin_palin_det_param: five parameterisations driven in lockstep, checked against
// hand tables and a bit-list reference model
module tb_fsm_bin_palin_det_param;
  logic clk = 1'b0;
  logic rst = 1'b0, ser_in = 1'b0, in_valid = 1'b0, clr = 1'b0;
  always #5 clk = ~clk;
  int lens [5] = '{3, 3, 5, 4, 3};
  int ovs  [5] = '{0, 1, 0, 0, 1};
  int cws  [5] = '{8, 8, 8, 8, 2};
  logic       dt0, dt1, dt2, dt3, dt4, bz0, bz1, bz2, bz3, bz4;
  logic [2:0] wd0, wd1, wd4;
  logic [4:0] wd2;
  logic [3:0] wd3;
  logic [7:0] ct0, ct1, ct2, ct3;
  logic [1:0] ct4;
  fsm_bin_palin_det_param #(.LEN(3), .OVERLAP(0), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .ser_in(ser_in),
    .in_valid(in_valid), .clr(clr), .det(dt0), .det_word(wd0), .det_cnt(ct0), .busy(bz0));
  fsm_bin_palin_det_param #(.LEN(3), .OVERLAP(1), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .ser_in(ser_in),
    .in_valid(in_valid), .clr(clr), .det(dt1), .det_word(wd1), .det_cnt(ct1), .busy(bz1));
  fsm_bin_palin_det_param #(.LEN(5), .OVERLAP(0), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .ser_in(ser_in),
    .in_valid(in_valid), .clr(clr), .det(dt2), .det_word(wd2), .det_cnt(ct2), .busy(bz2));
  fsm_bin_palin_det_param #(.LEN(4), .OVERLAP(0), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .ser_in(ser_in),
    .in_valid(in_valid), .clr(clr), .det(dt3), .det_word(wd3), .det_cnt(ct3), .busy(bz3));
  fsm_bin_palin_det_param #(.LEN(3), .OVERLAP(1), .CNT_W(2)) u4 (.clk(clk), .rst(rst), .ser_in(ser_in),
    .in_valid(in_valid), .clr(clr), .det(dt4), .det_word(wd4), .det_cnt(ct4), .busy(bz4));
  int a_det [5], a_word [5], a_cnt [5], a_busy [5];
  always_comb begin
    a_det  = '{int'(dt0), int'(dt1), int'(dt2), int'(dt3), int'(dt4)};
    a_word = '{int'(wd0), int'(wd1), int'(wd2), int'(wd3), int'(wd4)};
    a_cnt  = '{int'(ct0), int'(ct1), int'(ct2), int'(ct3), int'(ct4)};
    a_busy = '{int'(bz0), int'(bz1), int'(bz2), int'(bz3), int'(bz4)};
  end
  int checks = 0, errors = 0;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  // reference: list of accepted bits since the last frame start / clear
  int mh [5][32];
  int mn [5];
  int ed [5], ew [5], ec [5];
  task automatic model(input int s, input int v, input int c, input int r);
    for (int k = 0; k < 5; k++) begin
      ed[k] = 0;
      if (r == 0) begin
        mn[k] = 0; ew[k] = 0; ec[k] = 0;
      end else if (c != 0) begin
        mn[k] = 0; ec[k] = 0;
      end else if (v != 0) begin
        if (mn[k] == lens[k]) begin
          for (int j = 0; j < lens[k] - 1; j++) mh[k][j] = mh[k][j+1];
          mn[k]--;
        end
        mh[k][mn[k]] = s;
        mn[k]++;
        if (mn[k] == lens[k]) begin
          int pal = 1, word = 0;
          for (int j = 0; j < lens[k]; j++) begin
            if (mh[k][j] != mh[k][lens[k]-1-j]) pal = 0;
            word = word * 2 + mh[k][j];
          end
          if (pal != 0) begin
            ed[k] = 1;
            ew[k] = word;
            if (ec[k] != (1 << cws[k]) - 1) ec[k]++;
          end
          if (ovs[k] == 0) mn[k] = 0;
        end
      end
    end
  endtask
  task automatic step(input logic s, input logic v, input logic c, input logic r);
    ser_in = s; in_valid = v; clr = c; rst = r;
    model(int'(s), int'(v), int'(c), int'(r));
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("u%0d det", k), a_det[k], ed[k]);
      chk($sformatf("u%0d word", k), a_word[k], ew[k]);
      chk($sformatf("u%0d cnt", k), a_cnt[k], ec[k]);
      chk($sformatf("u%0d busy", k), a_busy[k], (mn[k] != 0 && mn[k] < lens[k]) ? 1 : 0);
    end
  endtask
  typedef struct {logic s, v, c, r; int det, word, cnt;} vec_t;
  vec_t tbl [10];
  initial begin
    // T1 on u0 (LEN=3 framed): 010 101 011
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 2, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 2, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 2, 1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 5, 2};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 5, 2};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 2};
    tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 2};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].c, tbl[i].r);
      chk($sformatf("T1[%0d] det", i), a_det[0], tbl[i].det);
      chk($sformatf("T1[%0d] word", i), a_word[0], tbl[i].word);
      chk($sformatf("T1[%0d] cnt", i), a_cnt[0], tbl[i].cnt);
    end
    // T2 on u1 (LEN=3 sliding): 0,1,0,1,0
    step(0, 0, 0, 0);
    step(0, 1, 0, 1); step(1, 1, 0, 1);
    step(0, 1, 0, 1); chk("T2 det3", a_det[1], 1);
    step(1, 1, 0, 1); chk("T2 det4", a_det[1], 1);
    step(0, 1, 0, 1); chk("T2 det5", a_det[1], 1);
    chk("T2 cnt", a_cnt[1], 3); chk("T2 word", a_word[1], 2);
    step(0, 0, 0, 1); chk("T2 idle det", a_det[1], 0);
    // T3 on u2 (LEN=5 framed): 10 gap gap 101
    step(0, 0, 0, 0);
    step(1, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 0, 0, 1); chk("T3 gap busy", a_busy[2], 1); chk("T3 gap det", a_det[2], 0);
    step(0, 0, 0, 1); chk("T3 gap2 busy", a_busy[2], 1);
    step(1, 1, 0, 1); step(0, 1, 0, 1); chk("T3 det4", a_det[2], 0);
    step(1, 1, 0, 1); chk("T3 det5", a_det[2], 1); chk("T3 word", a_word[2], 21);
    // T4 on u3 (LEN=4 framed): 0,1, clr+valid, 1,0,0,1
    step(0, 0, 0, 0);
    step(0, 1, 0, 1); step(1, 1, 0, 1);
    step(1, 1, 1, 1); chk("T4 clr busy", a_busy[3], 0);
    step(1, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 1, 0, 1); chk("T4 det", a_det[3], 1); chk("T4 word", a_word[3], 9); chk("T4 cnt", a_cnt[3], 1);
    // T5 on u4 (CNT_W=2 sliding): 8 zeros saturate at 3
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 1);
    chk("T5 det8", a_det[4], 1); chk("T5 cnt", a_cnt[4], 3);
    // T6 on u0: reset mid-window then 1,1,1
    step(0, 0, 0, 0);
    step(1, 1, 0, 1); step(0, 1, 0, 1);
    step(1, 1, 0, 0);
    chk("T6 rst det", a_det[0], 0); chk("T6 rst word", a_word[0], 0);
    chk("T6 rst cnt", a_cnt[0], 0); chk("T6 rst busy", a_busy[0], 0);
    step(1, 1, 0, 1); step(1, 1, 0, 1); chk("T6 det2", a_det[0], 0);
    step(1, 1, 0, 1); chk("T6 det3", a_det[0], 1); chk("T6 word", a_word[0], 7);
    // random traffic against the model
    for (int i = 0; i < 600; i++)
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 59) != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
